data_memory_ctrl: RTL and testbench

//  Word-organised data memory with a byte-lane controller. Sits at the far end of
//  the load/store path: accepts store data already packed into the low bits (byte,

---
 rtl/data_memory_ctrl.sv | 131 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte-lane store merge and low-aligned load return.
// Latency: MEM_LATENCY+2 cycles per access (request, BUSY x MEM_LATENCY, DONE); busywait high MEM_LATENCY+1 cycles.
// Backpressure: busywait stalls the requester; optional MISALIGN_TRAP_EN traps misaligned h/w accesses.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           wd_q;
  logic                  wr_q;
  logic                  mis_q;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           word;
  logic [31:0]           sh8;
  logic [31:0]           sh16;
  logic [31:0]           ldata;
  logic [3:0]            be;
  logic [31:0]           wbus;
  logic                  trap;
  logic                  access_now;
  logic                  unused_addr_bits;

  assign idx  = addr_q[ADDR_WIDTH+1:2];
  assign lane = addr_q[1:0];
  assign word = mem[idx];
  assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

`ifdef MISALIGN_TRAP_EN
  assign trap = ((f3_q[1:0] == 2'b01) && lane[0]) || ((f3_q == 3'b010) && (lane != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign access_now = RESET && (state == BUSY) && (cnt == 4'd0);
  assign busywait   = RESET && ((state == BUSY) || ((state == IDLE) && (mem_read || mem_write)));
  assign misaligned = mis_q;

  assign sh8  = word >> {lane, 3'b000};
  assign sh16 = word >> {lane[1], 4'b0000};

  always_comb begin
    case (f3_q)
      3'b000, 3'b100: ldata = {24'b0, sh8[7:0]};
      3'b001, 3'b101: ldata = {16'b0, sh16[15:0]};
      default:        ldata = word;
    endcase
  end

  // Store data is replicated across lanes so byte enables alone select the target.
  always_comb begin
    be   = 4'b0000;
    wbus = wd_q;
    case (f3_q)
      3'b000: begin
        be   = 4'b0001 << lane;
        wbus = {4{wd_q[7:0]}};
      end
      3'b001: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wbus = {2{wd_q[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(access_now && wr_q && !trap)) be = 4'b0000;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wbus[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      readdata <= 32'd0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q <= address[ADDR_WIDTH+1:0];
            f3_q   <= func3;
            wd_q   <= writedata;
            wr_q   <= mem_write;
            cnt    <= 4'(MEM_LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            mis_q <= trap;
            if (!wr_q) readdata <= trap ? 32'd0 : ldata;
          end
        end
        DONE: begin
          state <= IDLE;
          mis_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: transaction-level memory model plus per-cycle output compare.
module tb_data_memory_ctrl;

  localparam int LAT = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] address, writedata;
  logic [31:0] readdata;
  logic        busywait, misaligned;

  int n_pass = 0;
  int n_total = 0;

  bit          chk_en = 1'b0;
  logic        exp_bw, exp_mis;
  logic [31:0] exp_rd;
  logic [31:0] mdl [0:1023];

  data_memory_ctrl #(.ADDR_WIDTH(10), .MEM_LATENCY(LAT)) dut (
    .CLK(clk), .RESET(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .address(address), .writedata(writedata),
    .readdata(readdata), .busywait(busywait), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busywait",   {31'b0, busywait},   {31'b0, exp_bw});
      check("readdata",   readdata,            exp_rd);
      check("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
    end
  end

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = mdl[a[11:2]];
    case (f3)
      3'b000, 3'b100: return (w >> (8 * a[1:0])) & 32'h0000_00FF;
      3'b001, 3'b101: return (w >> (16 * a[1])) & 32'h0000_FFFF;
      default:        return w;
    endcase
  endfunction

  task automatic mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask, data;
    case (f3)
      3'b000: begin mask = 32'hFF << (8 * a[1:0]);   data = (wd & 32'hFF) << (8 * a[1:0]); end
      3'b001: begin mask = 32'hFFFF << (16 * a[1]);  data = (wd & 32'hFFFF) << (16 * a[1]); end
      3'b010: begin mask = 32'hFFFF_FFFF;            data = wd; end
      default: begin mask = 32'h0;                   data = 32'h0; end
    endcase
    mdl[a[11:2]] = (mdl[a[11:2]] & ~mask) | data;
  endtask

  // Called at posedge+2; returns at posedge+2 of the idle cycle after DONE.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int abort_k);
    int hi;
    bit trap;
    hi = 0;
    mem_read = rd; mem_write = wr; func3 = f3; address = a; writedata = wd;
    for (int k = 0; k <= LAT; k++) begin
      if (k == abort_k) rst_n = 1'b0;
      exp_bw  = (k == abort_k) ? 1'b0 : 1'b1;
      exp_mis = 1'b0;
      @(negedge clk);
      if (busywait) hi++;
      @(posedge clk); #2;
      if (k == abort_k) begin
        rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        exp_rd = 32'd0; exp_bw = 1'b0;
        return;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    exp_bw = 1'b0;
    trap = TRAP && (((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00)));
    if (trap) begin
      exp_mis = 1'b1;
      if (!wr) exp_rd = 32'd0;
    end else if (wr) begin
      mdl_store(f3, a, wd);
    end else begin
      exp_rd = mdl_load(f3, a);
    end
    @(negedge clk);
    if (busywait) hi++;
    @(posedge clk); #2;
    exp_mis = 1'b0;
    check("busy_cycles", hi, LAT + 1);
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    func3 = 3'b000; address = 32'd0; writedata = 32'd0;
    exp_bw = 1'b0; exp_mis = 1'b0; exp_rd = 32'd0;
    @(posedge clk); @(posedge clk); #2;
    mem_read = 1'b1;
    #1;
    check("rst_busywait", {31'b0, busywait}, 32'd0);
    mem_read = 1'b0;
    check("rst_readdata", readdata, 32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_en = 1'b1;

    access(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, -1);
    access(1, 0, 3'b010, 32'h10, 32'h0, -1);
    check("lw_0x10_a", readdata, 32'hDEAD_BEEF);

    access(0, 1, 3'b000, 32'h13, 32'h0000_00AA, -1);
    access(1, 0, 3'b010, 32'h10, 32'h0, -1);
    check("lw_after_sb", readdata, 32'hAAAD_BEEF);
    access(1, 0, 3'b100, 32'h13, 32'h0, -1);
    check("lbu_0x13", readdata, 32'h0000_00AA);

    access(0, 1, 3'b001, 32'h12, 32'h0000_1234, -1);
    access(1, 0, 3'b101, 32'h12, 32'h0, -1);
    check("lhu_0x12", readdata, 32'h0000_1234);
    access(1, 0, 3'b010, 32'h10, 32'h0, -1);
    check("lw_after_sh", readdata, 32'h1234_BEEF);

    access(1, 0, 3'b000, 32'h11, 32'h0, -1);
    check("lb_0x11", readdata, 32'h0000_00BE);
    access(1, 0, 3'b001, 32'h10, 32'h0, -1);
    check("lh_0x10", readdata, 32'h0000_BEEF);

    access(0, 1, 3'b010, 32'h10, 32'h0, 2);
    check("abort_readdata", readdata, 32'd0);
    access(1, 0, 3'b010, 32'h10, 32'h0, -1);
    check("lw_after_abort", readdata, 32'h1234_BEEF);

    access(0, 1, 3'b011, 32'h10, 32'hFFFF_FFFF, -1);
    access(1, 0, 3'b010, 32'h10, 32'h0, -1);
    check("lw_after_bad_f3", readdata, 32'h1234_BEEF);

    access(1, 1, 3'b010, 32'h20, 32'h1122_3344, -1);
    access(1, 0, 3'b010, 32'h20, 32'h0, -1);
    check("lw_0x20", readdata, 32'h1122_3344);

    access(1, 0, 3'b010, 32'h22, 32'h0, -1);
    check("lw_0x22", readdata, TRAP ? 32'h0 : 32'h1122_3344);

    access(0, 1, 3'b001, 32'h21, 32'h0000_5566, -1);
    access(1, 0, 3'b010, 32'h20, 32'h0, -1);
    check("lw_after_sh_0x21", readdata, TRAP ? 32'h1122_3344 : 32'h1122_5566);

    access(0, 1, 3'b000, 32'h20, 32'h0000_0077, -1);
    access(1, 0, 3'b000, 32'h20, 32'h0, -1);
    check("lb_0x20", readdata, 32'h0000_0077);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
